// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing, the packed sync/DE bundle, and line/frame total helpers.
package vga_pkg;

  localparam int DEF_CLK_DIV   = 4;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CNT_W     = 10;

  // Active-high decode bits; polarity is applied only at the top-level outputs.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bits_t;

  function automatic int h_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

  function automatic int v_total(input int visible, input int fp, input int sync, input int bp);
    return visible + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// vga_sync_delay: DEPTH-stage shift register for the raw sync/DE bits, advanced on pix_tick.
// Depth 0 is a plain wire so the outputs stay combinational from the counters.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       pix_tick,
  input  sync_bits_t din,
  output sync_bits_t dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk, reset, en, pix_tick};
      assign dout = din;
    end else begin : g_pipe
      sync_bits_t stage_reg [DEPTH];

      // Shift on each pixel tick; a disabled generator flushes every stage to inactive.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (!en) begin
          for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
        end else if (pix_tick) begin
          stage_reg[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
        end
      end

      assign dout = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: clk prescaler, horizontal/vertical counters, sync/DE decode and
// line/frame pulses. Every counter advance happens on the edge that raises pix_tick,
// so pix_tick, line_start and frame_start all mark the first clk of the new pixel.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int CNT_W     = DEF_CNT_W,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int PIPE_DLY  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_tick,
  output logic             h_sync,
  output logic             v_sync,
  output logic             DE,
  output logic [CNT_W-1:0] x_pixel,
  output logic [CNT_W-1:0] y_pixel,
  output logic             line_start,
  output logic             frame_start,
  output logic             v_blank
);

  localparam int H_TOTAL = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  // CLK_DIV tops out at 16, so the terminal count always fits in 4 bits.
  localparam int PRE_W = 4;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS  = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS  = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [PRE_W-1:0] presc_reg;
  logic             tick_next;
  logic [CNT_W-1:0] h_cnt_reg;
  logic [CNT_W-1:0] v_cnt_reg;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             pix_tick_reg;
  logic             line_start_reg;
  logic             frame_start_reg;
  sync_bits_t       raw_bits;
  sync_bits_t       dly_bits;

  // Terminal count of the prescaler: this edge begins a new pixel.
  assign tick_next = en && (presc_reg == PRE_LAST);

  // Prescaler cycles 0..CLK_DIV-1 while enabled and parks at 0 when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg <= '0;
    end else if (!en || (presc_reg == PRE_LAST)) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Next counter position with horizontal and vertical wrap.
  always_comb begin
    h_next = h_cnt_reg + 1'b1;
    v_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_next = '0;
      v_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
    end
  end

  // Idle parks the counters at the last position so the first tick wraps to (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt_reg <= H_LAST;
      v_cnt_reg <= V_LAST;
    end else if (!en) begin
      h_cnt_reg <= H_LAST;
      v_cnt_reg <= V_LAST;
    end else if (tick_next) begin
      h_cnt_reg <= h_next;
      v_cnt_reg <= v_next;
    end
  end

  // Strobes registered alongside the counter update; tick_next already carries en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_tick_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      pix_tick_reg    <= tick_next;
      line_start_reg  <= tick_next && (h_next == '0);
      frame_start_reg <= tick_next && (h_next == '0) && (v_next == '0);
    end
  end

  // Raw active-high decode; the idle position sits in both back porches, so it is inactive.
  always_comb begin
    raw_bits    = '0;
    raw_bits.hs = (h_cnt_reg >= HS_BEG) && (h_cnt_reg < HS_END);
    raw_bits.vs = (v_cnt_reg >= VS_BEG) && (v_cnt_reg < VS_END);
    raw_bits.de = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DLY)
  ) u_sync_delay (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pix_tick (tick_next),
    .din      (raw_bits),
    .dout     (dly_bits)
  );

  assign pix_tick    = pix_tick_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign x_pixel     = h_cnt_reg;
  assign y_pixel     = v_cnt_reg;
  assign v_blank     = (v_cnt_reg >= V_VIS);
  assign h_sync      = dly_bits.hs ? HS_POL : ~HS_POL;
  assign v_sync      = dly_bits.vs ? VS_POL : ~VS_POL;
  assign DE          = dly_bits.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on three configurations of vga_timing_gen:
// default 640x480 timing, a tiny 12x7 raster at CLK_DIV=1, and the tiny raster with PIPE_DLY=3.
module tb_vga_timing_gen;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- default instance ----------------
  logic       rst_d, en_d;
  logic       tick_d, hs_d, vs_d, de_d, ls_d, fs_d, vb_d;
  logic [9:0] x_d, y_d;

  vga_timing_gen u_def (
    .clk (clk), .reset (rst_d), .en (en_d), .pix_tick (tick_d),
    .h_sync (hs_d), .v_sync (vs_d), .DE (de_d), .x_pixel (x_d), .y_pixel (y_d),
    .line_start (ls_d), .frame_start (fs_d), .v_blank (vb_d)
  );

  // ---------------- tiny raster, CLK_DIV=1, HS_POL=1 ----------------
  logic       rst_s, en_s;
  logic       tick_s, hs_s, vs_s, de_s, ls_s, fs_s, vb_s;
  logic [3:0] x_s, y_s;

  vga_timing_gen #(
    .CLK_DIV (1), .H_VISIBLE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_VISIBLE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .CNT_W (4),
    .HS_POL (1'b1), .VS_POL (1'b0), .PIPE_DLY (0)
  ) u_small (
    .clk (clk), .reset (rst_s), .en (en_s), .pix_tick (tick_s),
    .h_sync (hs_s), .v_sync (vs_s), .DE (de_s), .x_pixel (x_s), .y_pixel (y_s),
    .line_start (ls_s), .frame_start (fs_s), .v_blank (vb_s)
  );

  // ---------------- tiny raster, CLK_DIV=2, PIPE_DLY=3 ----------------
  logic       rst_p, en_p;
  logic       tick_p, hs_p, vs_p, de_p, ls_p, fs_p, vb_p;
  logic [3:0] x_p, y_p;

  vga_timing_gen #(
    .CLK_DIV (2), .H_VISIBLE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_VISIBLE (4), .V_FP (1), .V_SYNC (1), .V_BP (1), .CNT_W (4),
    .HS_POL (1'b1), .VS_POL (1'b0), .PIPE_DLY (3)
  ) u_pipe (
    .clk (clk), .reset (rst_p), .en (en_p), .pix_tick (tick_p),
    .h_sync (hs_p), .v_sync (vs_p), .DE (de_p), .x_pixel (x_p), .y_pixel (y_p),
    .line_start (ls_p), .frame_start (fs_p), .v_blank (vb_p)
  );

  typedef struct {
    logic        en;
    int          ncyc;
    logic [14:0] exp;
  } vec_t;

  typedef struct {
    int          p;
    logic [14:0] exp;
  } pvec_t;

  vec_t  vec [19];
  pvec_t pv  [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Packed view {tick, x, y, hs, vs, de, ls, fs, vb} for the 4-bit instances.
  function automatic logic [14:0] pk(input logic t, input int x, input int y,
                                     input logic hs, input logic vs, input logic de,
                                     input logic ls, input logic fs, input logic vb);
    return {t, 4'(x), 4'(y), hs, vs, de, ls, fs, vb};
  endfunction

  // Edges from now until frame_start on the default instance.
  task automatic def_fs_latency(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!fs_d && n < 20);
    check(name, n, 4);
    check({name, "_xy"}, {22'd0, x_d, y_d} , 32'd0);
  endtask

  task automatic def_wait_x(input int target, input string name);
    int n;
    n = 0;
    while (x_d != 10'(target) && n < 4000) begin
      @(posedge clk); #1; n++;
    end
    check(name, x_d, target);
  endtask

  initial begin
    int n, lines, tick_n, hs_n, de_n, hs_first, hs_last, last_tick, gap_bad, prev_p;
    logic [14:0] got;

    // Tiny raster: H 0..7 visible, 8 FP, 9..10 sync (active high), 11 BP; V 0..3, 4, 5 (low), 6.
    vec[0]  = '{1'b1, 1,  pk(1, 0, 0, 0, 1, 1, 1, 1, 0)};
    vec[1]  = '{1'b1, 1,  pk(1, 1, 0, 0, 1, 1, 0, 0, 0)};
    vec[2]  = '{1'b1, 7,  pk(1, 8, 0, 0, 1, 0, 0, 0, 0)};
    vec[3]  = '{1'b1, 1,  pk(1, 9, 0, 1, 1, 0, 0, 0, 0)};
    vec[4]  = '{1'b1, 1,  pk(1, 10, 0, 1, 1, 0, 0, 0, 0)};
    vec[5]  = '{1'b1, 1,  pk(1, 11, 0, 0, 1, 0, 0, 0, 0)};
    vec[6]  = '{1'b1, 1,  pk(1, 0, 1, 0, 1, 1, 1, 0, 0)};
    vec[7]  = '{1'b1, 35, pk(1, 11, 3, 0, 1, 0, 0, 0, 0)};
    vec[8]  = '{1'b1, 1,  pk(1, 0, 4, 0, 1, 0, 1, 0, 1)};
    vec[9]  = '{1'b1, 12, pk(1, 0, 5, 0, 0, 0, 1, 0, 1)};
    vec[10] = '{1'b1, 11, pk(1, 11, 5, 0, 0, 0, 0, 0, 1)};
    vec[11] = '{1'b1, 1,  pk(1, 0, 6, 0, 1, 0, 1, 0, 1)};
    vec[12] = '{1'b1, 11, pk(1, 11, 6, 0, 1, 0, 0, 0, 1)};
    vec[13] = '{1'b1, 1,  pk(1, 0, 0, 0, 1, 1, 1, 1, 0)};
    vec[14] = '{1'b0, 1,  pk(0, 11, 6, 0, 1, 0, 0, 0, 1)};
    vec[15] = '{1'b0, 3,  pk(0, 11, 6, 0, 1, 0, 0, 0, 1)};
    vec[16] = '{1'b1, 1,  pk(1, 0, 0, 0, 1, 1, 1, 1, 0)};
    vec[17] = '{1'b1, 9,  pk(1, 9, 0, 1, 1, 0, 0, 0, 0)};
    vec[18] = '{1'b0, 1,  pk(0, 11, 6, 0, 1, 0, 0, 0, 1)};

    // Pipelined raster: sync/DE lag the counters by three pixel ticks.
    pv[0] = '{0,  pk(1, 0, 0, 0, 1, 0, 1, 1, 0)};
    pv[1] = '{1,  pk(1, 1, 0, 0, 1, 0, 0, 0, 0)};
    pv[2] = '{2,  pk(1, 2, 0, 0, 1, 0, 0, 0, 0)};
    pv[3] = '{3,  pk(1, 3, 0, 0, 1, 1, 0, 0, 0)};
    pv[4] = '{10, pk(1, 10, 0, 0, 1, 1, 0, 0, 0)};
    pv[5] = '{11, pk(1, 11, 0, 0, 1, 0, 0, 0, 0)};
    pv[6] = '{12, pk(1, 0, 1, 1, 1, 0, 1, 0, 0)};
    pv[7] = '{13, pk(1, 1, 1, 1, 1, 0, 0, 0, 0)};
    pv[8] = '{14, pk(1, 2, 1, 0, 1, 0, 0, 0, 0)};
    pv[9] = '{15, pk(1, 3, 1, 0, 1, 1, 0, 0, 0)};

    rst_d = 1'b0; en_d = 1'b1;
    rst_s = 1'b0; en_s = 1'b0;
    rst_p = 1'b0; en_p = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state of the default instance, with en already high.
    check("rst_x", x_d, 799);
    check("rst_y", y_d, 524);
    check("rst_flags", {tick_d, hs_d, vs_d, de_d, ls_d, fs_d, vb_d}, 7'b0110001);

    // ---- table-driven run of the tiny raster ----
    rst_s = 1'b1;
    for (int r = 0; r < 19; r++) begin
      en_s = vec[r].en;
      repeat (vec[r].ncyc) @(posedge clk);
      #1;
      got = {tick_s, x_s, y_s, hs_s, vs_s, de_s, ls_s, fs_s, vb_s};
      $display("vec %0d en=%0b x=%0d y=%0d hs=%0b vs=%0b de=%0b", r, vec[r].en, x_s, y_s, hs_s, vs_s, de_s);
      check($sformatf("small_vec%0d", r), got, vec[r].exp);
    end

    // ---- tiny raster frame length and line count ----
    en_s = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!fs_s && n < 10);
    check("small_first_fs", n, 1);
    n = 0; lines = 0;
    do begin
      @(posedge clk); #1; n++;
      if (ls_s) lines++;
    end while (!fs_s && n < 200);
    check("small_frame_clk", n, 84);
    check("small_lines", lines, 7);
    $display("small frame clk=%0d lines=%0d", n, lines);

    // ---- PIPE_DLY=3 instance ----
    rst_p = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!fs_p && n < 10);
    check("pipe_first_fs", n, 2);
    prev_p = 0;
    for (int k = 0; k < 10; k++) begin
      repeat (2 * (pv[k].p - prev_p)) @(posedge clk);
      if (pv[k].p != prev_p) #1;
      prev_p = pv[k].p;
      got = {tick_p, x_p, y_p, hs_p, vs_p, de_p, ls_p, fs_p, vb_p};
      $display("pipe p=%0d x=%0d y=%0d de=%0b hs=%0b", pv[k].p, x_p, y_p, de_p, hs_p);
      check($sformatf("pipe_p%0d", pv[k].p), got, pv[k].exp);
    end

    // ---- default instance: release, first frame_start ----
    rst_d = 1'b1;
    def_fs_latency("def_rel_fs");

    // ---- default instance: one full line ----
    n = 0; tick_n = 0; hs_n = 0; de_n = 0; hs_first = -1; hs_last = -1; last_tick = -1; gap_bad = 0;
    do begin
      if (tick_d) begin
        tick_n++;
        if (last_tick >= 0 && (n - last_tick) != 4) gap_bad++;
        last_tick = n;
        if (!hs_d) begin
          if (hs_first < 0) hs_first = int'(x_d);
          hs_last = int'(x_d);
          hs_n++;
        end
        if (de_d) de_n++;
      end
      @(posedge clk); #1; n++;
    end while (!ls_d && n < 4000);
    $display("def line clk=%0d ticks=%0d hs=%0d..%0d de=%0d", n, tick_n, hs_first, hs_last, de_n);
    check("def_line_clk", n, 3200);
    check("def_ticks", tick_n, 800);
    check("def_tick_gap", gap_bad, 0);
    check("def_hs_cnt", hs_n, 96);
    check("def_hs_first", hs_first, 656);
    check("def_hs_last", hs_last, 751);
    check("def_de_cnt", de_n, 640);
    check("def_line1_y", y_d, 1);

    // ---- default instance: reset mid-sync ----
    def_wait_x(700, "def_reach_700a");
    check("def_hs_700a", hs_d, 0);
    rst_d = 1'b0;
    #1;
    check("def_arst_x", x_d, 799);
    check("def_arst_y", y_d, 524);
    check("def_arst_flags", {tick_d, hs_d, vs_d, de_d, ls_d, fs_d, vb_d}, 7'b0110001);
    @(posedge clk); #1;
    rst_d = 1'b1;
    def_fs_latency("def_arst_fs");

    // ---- default instance: en dropped mid-sync ----
    def_wait_x(700, "def_reach_700b");
    check("def_hs_700b", hs_d, 0);
    en_d = 1'b0;
    @(posedge clk); #1;
    check("def_en0_x", x_d, 799);
    check("def_en0_y", y_d, 524);
    check("def_en0_flags", {tick_d, hs_d, vs_d, de_d, ls_d, fs_d, vb_d}, 7'b0110001);
    en_d = 1'b1;
    def_fs_latency("def_en1_fs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per pixel; legal range 1..16.
REQ-002 Parameters H_VISIBLE, H_FP, H_SYNC, H_BP have defaults 640, 16, 96, 48 (pixels).
REQ-003 Parameters V_VISIBLE, V_FP, V_SYNC, V_BP have defaults 480, 10, 2, 33 (lines).
REQ-004 Parameter CNT_W, default 10: counter and coordinate width; must satisfy 2**CNT_W >= max(H_TOTAL, V_TOTAL).
REQ-005 Parameters HS_POL and VS_POL, default 0: asserted level of h_sync and v_sync.
REQ-006 Parameter PIPE_DLY, default 0: sync/DE delay in pixel ticks; legal range 0..15.
REQ-007 clk  in  1  single system clock; all flops sample on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 en  in  1  run enable; low holds the generator in its idle state.
REQ-010 pix_tick  out  1  one-clk pixel-enable strobe.
REQ-011 h_sync, v_sync  out  1 each  sync outputs with programmable polarity.
REQ-012 DE  out  1  data enable (visible region).
REQ-013 x_pixel, y_pixel  out  CNT_W each  current h/v counter values.
REQ-014 line_start, frame_start  out  1 each  one-clk pulses.
REQ-015 v_blank  out  1  high while y_pixel >= V_VISIBLE.

Function
REQ-016 Derived totals: H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP; V_TOTAL is formed the same way from the V_ parameters; H_BP and V_BP must be >= 1.
REQ-017 Prescaler: counts 0..CLK_DIV-1; pix_tick is registered and is high exactly when the prescaler equals CLK_DIV-1; with CLK_DIV=1, pix_tick is constantly high while en=1.
REQ-018 No derived or gated clocks; all pixel-rate logic uses pix_tick as a clock enable.
REQ-019 Horizontal counter: on pix_tick, h_cnt increments; from H_TOTAL-1 it wraps to 0.
REQ-020 Vertical counter: v_cnt increments only on pix_tick with h_cnt = H_TOTAL-1; from V_TOTAL-1 it wraps to 0.
REQ-021 Raw h_sync is asserted for H_VISIBLE+H_FP <= h_cnt < H_VISIBLE+H_FP+H_SYNC; raw v_sync uses the same window on v_cnt with the V_ parameters.
REQ-022 Raw DE = (h_cnt < H_VISIBLE) and (v_cnt < V_VISIBLE).
REQ-023 x_pixel = h_cnt and y_pixel = v_cnt, undelayed.
REQ-024 h_sync, v_sync and DE equal the raw decode delayed by PIPE_DLY pix_ticks; with PIPE_DLY=0 they are combinational from the counters.
REQ-025 line_start is high for the one clk cycle in which h_cnt first holds 0; frame_start is high for that cycle only when v_cnt is also 0.
REQ-026 v_blank is undelayed.
REQ-027 en deasserted: on the next edge, the prescaler is cleared and the counters are loaded to (H_TOTAL-1, V_TOTAL-1); all delay stages become inactive; no pulses are generated.
REQ-028 en asserted: the first pix_tick occurs CLK_DIV clk cycles later and wraps the counters to (0,0), so frame_start follows.
REQ-029 en toggling mid-line or mid-frame never produces a partial sync pulse longer than its nominal width.

Reset
REQ-030 While reset is low: prescaler 0; pix_tick 0; h_cnt = H_TOTAL-1; v_cnt = V_TOTAL-1; delay stages inactive.
REQ-031 While reset is low: h_sync = ~HS_POL; v_sync = ~VS_POL; DE 0; line_start and frame_start 0; v_blank 1.
REQ-032 Reset release is synchronous-safe: the first pix_tick comes CLK_DIV cycles after release (if en=1) and the first line is line 0.

Structure
REQ-033 Package vga_pkg holds the default timing localparams and the H_TOTAL/V_TOTAL helper functions.
REQ-034 Sub-module vga_sync_delay is a PIPE_DLY-deep, pix_tick-enabled shift register for {h_sync, v_sync, DE}, with a pass-through at depth 0.

Verification
REQ-035 Defaults: pix_tick period is 4 clk; line_start period is 3200 clk; frame_start period is 1,680,000 clk.
REQ-036 Defaults: h_sync is low for h=656..751 (96 ticks); v_sync is low for lines 490..491; 307,200 DE ticks occur per frame.
REQ-037 PIPE_DLY=3: DE rises 3 pix_ticks after x_pixel=0 on line 0, and x/y timing is unchanged.
REQ-038 H=8/1/2/1, V=4/1/1/1, CLK_DIV=1, HS_POL=1: h_sync is high at h=9..10, the line is 12 clk long, the frame is 84 clk long, and wrap occurs at (11,6)->(0,0).
REQ-039 Reset asserted, and separately en dropped, mid-sync at h=700: outputs go idle per REQ-030..031 or REQ-027, and after release the first frame_start occurs exactly CLK_DIV clk later.
